traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_phase_ctrl_pkg.sv | 50 +++++
 rtl/traffic_phase_ctrl_bin2bcd5.sv | 24 ++
 rtl/traffic_phase_ctrl.sv | 137 +++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared types and constants for the intersection phase controller.
// The FLASH encoding is only reachable when NIGHT_FLASH_EN is defined.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } phase_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [3:0] BLANK = 4'hF;

  // Leaving FLASH re-enters the cycle through the second all-red clearance.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      NS_G:    n = NS_Y;
      NS_Y:    n = AR1;
      AR1:     n = EW_G;
      EW_G:    n = EW_Y;
      EW_Y:    n = AR2;
      AR2:     n = NS_G;
      default: n = AR2;
    endcase
    return n;
  endfunction

  // Returns {ns_light, ew_light}.
  function automatic logic [5:0] lamps_of(input phase_e p, input logic blink);
    logic [5:0] l;
    case (p)
      NS_G:    l = {L_GRN, L_RED};
      NS_Y:    l = {L_YEL, L_RED};
      EW_G:    l = {L_RED, L_GRN};
      EW_Y:    l = {L_RED, L_YEL};
      FLASH:   l = blink ? {L_YEL, L_YEL} : {L_OFF, L_OFF};
      default: l = {L_RED, L_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_bin2bcd5.sv
// Combinational 5-bit binary to two-digit BCD converter (input range 0..31).
module bin2bcd5 (
  input  logic [4:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  always_comb begin
    if (bin_i >= 5'd30) begin
      tens_o = 4'd3;
      ones_o = 4'(bin_i - 5'd30);
    end else if (bin_i >= 5'd20) begin
      tens_o = 4'd2;
      ones_o = 4'(bin_i - 5'd20);
    end else if (bin_i >= 5'd10) begin
      tens_o = 4'd1;
      ones_o = 4'(bin_i - 5'd10);
    end else begin
      tens_o = 4'd0;
      ones_o = 4'(bin_i);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with per-phase countdown, BCD display and pedestrian cut.
// Optional night flashing mode is enabled by defining NIGHT_FLASH_EN.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN   = 20,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 1,
  parameter int T_PED_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       pause,
  input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output phase_e     phase,
  output logic [4:0] remain,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       ped_pend
);

  localparam logic [3:0] RST_TENS = 4'(T_GREEN / 10);
  localparam logic [3:0] RST_ONES = 4'(T_GREEN % 10);

  phase_e     phase_q, phase_d;
  logic [4:0] remain_q, remain_d;
  logic       ped_pend_q, ped_pend_d;
  logic       ped_prev_q;
  logic       blink_q, blink_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic [3:0] bcd_tens, bcd_ones;

  logic step, ped_rise, is_green;
  assign step     = tick && !pause;
  assign ped_rise = ped_req && !ped_prev_q;
  assign is_green = (phase_q == NS_G) || (phase_q == EW_G);

  function automatic logic [4:0] dur_of(input phase_e p);
    logic [4:0] d;
    case (p)
      NS_G, EW_G: d = 5'(T_GREEN);
      NS_Y, EW_Y: d = 5'(T_YELLOW);
      default:    d = 5'(T_ALLRED);
    endcase
    return d;
  endfunction

  always_comb begin
    phase_d    = phase_q;
    remain_d   = remain_q;
    ped_pend_d = ped_pend_q;
    blink_d    = blink_q;

    // A phase expiry takes priority over a pending pedestrian cut.
    if (step && remain_q == 5'd1) begin
      phase_d  = next_phase(phase_q);
      remain_d = dur_of(phase_d);
    end else if (ped_pend_q && !pause && is_green) begin
      ped_pend_d = 1'b0;
      if (remain_q > 5'(T_PED_MIN)) begin
        remain_d = 5'(T_PED_MIN);
      end else if (step) begin
        remain_d = remain_q - 5'd1;
      end
    end else if (step) begin
      remain_d = remain_q - 5'd1;
    end

    if (ped_rise) begin
      ped_pend_d = 1'b1;
    end

`ifdef NIGHT_FLASH_EN
    if (night) begin
      phase_d    = FLASH;
      remain_d   = 5'd0;
      ped_pend_d = 1'b0;
      blink_d    = (phase_q == FLASH) ? (blink_q ^ step) : 1'b1;
    end else if (phase_q == FLASH) begin
      phase_d    = AR2;
      remain_d   = 5'(T_ALLRED);
      ped_pend_d = 1'b0;
      blink_d    = 1'b0;
    end
`endif

    {ns_d, ew_d} = lamps_of(phase_d, blink_d);
    tens_d = (phase_d == FLASH) ? BLANK : bcd_tens;
    ones_d = (phase_d == FLASH) ? BLANK : bcd_ones;
  end

  bin2bcd5 u_bcd (
    .bin_i  (remain_d),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= NS_G;
      remain_q   <= 5'(T_GREEN);
      ped_pend_q <= 1'b0;
      ped_prev_q <= 1'b0;
      blink_q    <= 1'b0;
      ns_q       <= L_GRN;
      ew_q       <= L_RED;
      tens_q     <= RST_TENS;
      ones_q     <= RST_ONES;
    end else begin
      phase_q    <= phase_d;
      remain_q   <= remain_d;
      ped_pend_q <= ped_pend_d;
      ped_prev_q <= ped_req;
      blink_q    <= blink_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
    end
  end

  assign phase      = phase_q;
  assign remain     = remain_q;
  assign ped_pend   = ped_pend_q;
  assign ns_light   = ns_q;
  assign ew_light   = ew_q;
  assign digit_tens = tens_q;
  assign digit_ones = ones_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: a full-cycle vector table plus pedestrian,
// pause, reset and (with NIGHT_FLASH_EN) night-flash sequences.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       pause = 1'b0;
  logic       ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
  logic       night = 1'b0;
`endif
  logic [2:0] ns_light, ew_light;
  phase_e     phase;
  logic [4:0] remain;
  logic [3:0] digit_tens, digit_ones;
  logic       ped_pend;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_blink = 1'b0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .pause      (pause),
    .ped_req    (ped_req),
`ifdef NIGHT_FLASH_EN
    .night      (night),
`endif
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .phase      (phase),
    .remain     (remain),
    .digit_tens (digit_tens),
    .digit_ones (digit_ones),
    .ped_pend   (ped_pend)
  );

  typedef struct {
    logic       t;
    logic       p;
    logic       r;
    phase_e     ph;
    logic [4:0] rem;
    logic       pend;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string name, input string field, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic check(input string name, input phase_e ph, input int rem, input logic pend);
    logic [5:0] lamps;
    logic [3:0] et, eo;
    case (ph)
      NS_G:    lamps = {3'b001, 3'b100};
      NS_Y:    lamps = {3'b010, 3'b100};
      EW_G:    lamps = {3'b100, 3'b001};
      EW_Y:    lamps = {3'b100, 3'b010};
      FLASH:   lamps = exp_blink ? {3'b010, 3'b010} : 6'b000000;
      default: lamps = {3'b100, 3'b100};
    endcase
    if (ph == FLASH) begin
      et = 4'hF;
      eo = 4'hF;
    end else begin
      et = 4'(rem / 10);
      eo = 4'(rem % 10);
    end
    cmp(name, "phase", int'(phase), int'(ph));
    cmp(name, "remain", int'(remain), rem);
    cmp(name, "ped_pend", int'(ped_pend), int'(pend));
    cmp(name, "ns_light", int'(ns_light), int'(lamps[5:3]));
    cmp(name, "ew_light", int'(ew_light), int'(lamps[2:0]));
    cmp(name, "digit_tens", int'(digit_tens), int'(et));
    cmp(name, "digit_ones", int'(digit_ones), int'(eo));
    $display("%s: phase=%0d remain=%0d pend=%0b ns=%b ew=%b digits=%h%h",
             name, phase, remain, ped_pend, ns_light, ew_light, digit_tens, digit_ones);
  endtask

  task automatic step(input logic t, input logic p, input logic r);
    @(negedge clk);
    tick    = t;
    pause   = p;
    ped_req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    tick    = 1'b0;
    pause   = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  phase_e seq_ph[6] = '{NS_G, NS_Y, AR1, EW_G, EW_Y, AR2};
  int     seq_t[6]  = '{20, 3, 1, 20, 3, 1};

  initial begin
    vec_t v;
    // Full cycle: one row per tick, plus a paused tick and an idle cycle early on.
    for (int s = 0; s < 6; s++) begin
      for (int j = 1; j <= seq_t[s]; j++) begin
        v.t = 1'b1; v.p = 1'b0; v.r = 1'b0; v.pend = 1'b0;
        if (j < seq_t[s]) begin
          v.ph  = seq_ph[s];
          v.rem = 5'(seq_t[s] - j);
        end else begin
          v.ph  = seq_ph[(s + 1) % 6];
          v.rem = 5'(seq_t[(s + 1) % 6]);
        end
        vecs.push_back(v);
        if (s == 0 && j == 2) begin
          v.t = 1'b1; v.p = 1'b1;
          vecs.push_back(v);
          v.t = 1'b0; v.p = 1'b0;
          vecs.push_back(v);
        end
      end
    end

    do_reset();
    check("reset", NS_G, 20, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].t, vecs[i].p, vecs[i].r);
      check($sformatf("vec%0d", i), vecs[i].ph, int'(vecs[i].rem), vecs[i].pend);
    end

    // Pedestrian cut in NS_G above and below T_PED_MIN.
    do_reset();
    ticks(5);
    check("ped_r15", NS_G, 15, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("ped_latch", NS_G, 15, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("ped_cut", NS_G, 5, 1'b0);
    ticks(2);
    step(1'b0, 1'b0, 1'b1);
    check("ped_low_latch", NS_G, 3, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("ped_low_clear", NS_G, 3, 1'b0);

    // Request during yellow is held through all-red and served in EW_G.
    ticks(3);
    check("nsy_enter", NS_Y, 3, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("nsy_latch", NS_Y, 3, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    ticks(2);
    check("ar1_hold", AR1, 1, 1'b1);
    ticks(1);
    check("ewg_first", EW_G, 20, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("ewg_cut", EW_G, 5, 1'b0);

    // Reset from mid-phase.
    do_reset();
    check("reset_mid", NS_G, 20, 1'b0);

    // Pause freezes the countdown but still latches a request edge.
    ticks(8);
    check("pause_r12", NS_G, 12, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("pause_hold", NS_G, 12, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("pause_release", NS_G, 5, 1'b0);

    // Expiry tick wins over a pending cut; request carries to the next green.
    do_reset();
    ticks(19);
    check("exp_r1", NS_G, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("exp_latch", NS_G, 1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("exp_wins", NS_Y, 3, 1'b1);
    ticks(4);
    check("exp_ewg", EW_G, 20, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("exp_served", EW_G, 5, 1'b0);
    // At or below T_PED_MIN a same-cycle tick still decrements while the request clears.
    ticks(2);
    step(1'b0, 1'b0, 1'b1);
    check("low_tick_latch", EW_G, 3, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("low_tick_dec", EW_G, 2, 1'b0);

`ifdef NIGHT_FLASH_EN
    do_reset();
    ticks(29);
    check("night_pre", EW_G, 15, 1'b0);
    @(negedge clk);
    night = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    exp_blink = 1'b1;
    check("flash_enter", FLASH, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp_blink = 1'b0;
    check("flash_off", FLASH, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp_blink = 1'b1;
    check("flash_on", FLASH, 0, 1'b0);
    @(negedge clk);
    night = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("night_exit", AR2, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("night_nsg", NS_G, 20, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
